// File: rtl/axi_pkg.sv
// Shared AXI encodings and the write-slave state type.
// Used by the write slave and its burst address helper.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_RESP = 2'b10
  } state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for FIXED, INCR and WRAP bursts.
// Purely combinational so read and write slaves can share it.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] span;

  always_comb begin
    step      = AW'(1) << size;
    span      = (AW'(len) + AW'(1)) << size;
    next_addr = addr;
    unique case (1'b1)
      (burst == BURST_INCR):
        next_addr = (addr & ~(step - AW'(1))) + step;
      (burst == BURST_WRAP):
        next_addr = (addr & ~(span - AW'(1))) |
                    ((addr + step) & (span - AW'(1)));
      default:
        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write-channel slave: one burst at a time, per-beat
// registered memory writes and a single B response.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            axi_aclk,
  input  logic            rst,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [2:0]      axi_awsize,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [1:0]      axi_bresp,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb
);

  localparam int MAX_SIZE = $clog2(DW / 8);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic          cfg_err;
  logic          proto_err;
  logic [1:0]    bresp_q;

  logic [AW-1:0] next_addr;
  logic          aw_err;
  logic          last_beat;
  logic          mism;
  logic          w_hs;

  axi_burst_addr #(.AW(AW)) u_addr (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign axi_awready = (state == S_IDLE);
  assign axi_wready  = (state == S_DATA);
  assign axi_bvalid  = (state == S_RESP);
  assign axi_bresp   = bresp_q;

  assign last_beat = (beat_q == len_q);
  assign mism      = (axi_wlast != last_beat);
  assign w_hs      = axi_wvalid && (state == S_DATA);

  // Configuration errors suppress memory writes for the whole burst.
  always_comb begin
    aw_err = (axi_awburst == BURST_RSVD) ||
             (int'(axi_awsize) > MAX_SIZE);
    if (axi_awburst == BURST_WRAP) begin
      if (!wrap_len_ok(axi_awlen) ||
          ((axi_awaddr & ((AW'(1) << axi_awsize) - AW'(1))) != '0))
        aw_err = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cfg_err   <= 1'b0;
      proto_err <= 1'b0;
      bresp_q   <= RESP_OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (axi_awvalid) begin
            addr_q    <= axi_awaddr;
            len_q     <= axi_awlen;
            size_q    <= axi_awsize;
            burst_q   <= axi_awburst;
            beat_q    <= '0;
            cfg_err   <= aw_err;
            proto_err <= 1'b0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            if (!cfg_err) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_q;
              mem_wdata <= axi_wdata;
              mem_wstrb <= axi_wstrb;
            end
            addr_q    <= next_addr;
            beat_q    <= beat_q + 8'd1;
            proto_err <= proto_err | mism;
            if (last_beat) begin
              state   <= S_RESP;
              bresp_q <= (cfg_err | proto_err | mism) ?
                         RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_RESP: begin
          if (axi_bready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed self-checking bench for axi_wr_slave.
// Outputs are sampled 1ns after each rising edge.
module tb_axi_wr_slave;

  logic        axi_aclk = 1'b0;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_addr [16];

  always #5 axi_aclk = ~axi_aclk;

  axi_wr_slave dut (
    .axi_aclk    (axi_aclk),
    .rst         (rst),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb)
  );

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3);
  endfunction

  // One burst; hold>0 also exercises B backpressure with a pending AW.
  task automatic burst(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt,
                       input int gap, input int bad_last,
                       input logic we_exp, input logic [1:0] resp_exp,
                       input int hold);
    axi_awaddr  = addr;
    axi_awlen   = len;
    axi_awsize  = size;
    axi_awburst = bt;
    axi_awvalid = 1'b1;
    step();
    chk("aw_awready", 64'(axi_awready), 64'd0);
    chk("aw_wready", 64'(axi_wready), 64'd1);
    axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gap != 0) begin
        axi_wvalid = 1'b0;
        step();
        chk("gap_we", 64'(mem_we), 64'd0);
      end
      axi_wvalid = 1'b1;
      axi_wdata  = beat_data(i);
      axi_wstrb  = 8'h0F ^ 8'(i);
      axi_wlast  = (i == int'(len)) || (i == bad_last);
      step();
      chk("beat_we", 64'(mem_we), 64'(we_exp));
      if (we_exp) begin
        chk("beat_addr", 64'(mem_addr), 64'(exp_addr[i]));
        chk("beat_data", mem_wdata, beat_data(i));
        chk("beat_strb", 64'(mem_wstrb), 64'(8'h0F ^ 8'(i)));
      end
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    chk("end_wready", 64'(axi_wready), 64'd0);
    chk("end_bvalid", 64'(axi_bvalid), 64'd1);
    chk("end_bresp", 64'(axi_bresp), 64'(resp_exp));
    if (hold > 0) begin
      axi_awaddr  = 32'h200;
      axi_awlen   = 8'd0;
      axi_awsize  = 3'd3;
      axi_awburst = 2'b01;
      axi_awvalid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        step();
        chk("hold_bvalid", 64'(axi_bvalid), 64'd1);
        chk("hold_bresp", 64'(axi_bresp), 64'(resp_exp));
        chk("hold_awready", 64'(axi_awready), 64'd0);
      end
    end
    axi_bready = 1'b1;
    step();
    axi_bready = 1'b0;
    chk("b_bvalid", 64'(axi_bvalid), 64'd0);
    chk("b_awready", 64'(axi_awready), 64'd1);
    if (hold > 0) begin
      step();
      axi_awvalid = 1'b0;
      chk("next_aw_taken", 64'(axi_awready), 64'd0);
      chk("next_wready", 64'(axi_wready), 64'd1);
      axi_wvalid = 1'b1;
      axi_wdata  = 64'h1234;
      axi_wstrb  = 8'hFF;
      axi_wlast  = 1'b1;
      step();
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
      chk("next_we", 64'(mem_we), 64'd1);
      chk("next_addr", 64'(mem_addr), 64'h200);
      chk("next_bresp", 64'(axi_bresp), 64'd0);
      axi_bready = 1'b1;
      step();
      axi_bready = 1'b0;
      chk("next_bdone", 64'(axi_bvalid), 64'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awsize  = '0;
    axi_awburst = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    step();
    step();
    chk("rst_awready", 64'(axi_awready), 64'd1);
    chk("rst_wready", 64'(axi_wready), 64'd0);
    chk("rst_bvalid", 64'(axi_bvalid), 64'd0);
    chk("rst_bresp", 64'(axi_bresp), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
    rst = 1'b0;

    // W before AW is held off
    axi_wvalid = 1'b1;
    axi_wdata  = 64'hDEAD;
    axi_wlast  = 1'b1;
    step();
    chk("early_wready", 64'(axi_wready), 64'd0);
    chk("early_we", 64'(mem_we), 64'd0);
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;

    exp_addr[0] = 32'h100; exp_addr[1] = 32'h108;
    exp_addr[2] = 32'h110; exp_addr[3] = 32'h118;
    burst(32'h100, 8'd3, 3'd3, 2'b01, 0, -1, 1'b1, 2'b00, 0);

    exp_addr[0] = 32'h118; exp_addr[1] = 32'h100;
    exp_addr[2] = 32'h108; exp_addr[3] = 32'h110;
    burst(32'h118, 8'd3, 3'd3, 2'b10, 0, -1, 1'b1, 2'b00, 0);

    exp_addr[0] = 32'h40; exp_addr[1] = 32'h40;
    exp_addr[2] = 32'h40;
    burst(32'h40, 8'd2, 3'd3, 2'b00, 1, -1, 1'b1, 2'b00, 0);

    exp_addr[0] = 32'h100; exp_addr[1] = 32'h108;
    exp_addr[2] = 32'h110; exp_addr[3] = 32'h118;
    burst(32'h100, 8'd3, 3'd3, 2'b01, 0, 1, 1'b1, 2'b10, 0);

    burst(32'h40, 8'd1, 3'd3, 2'b11, 0, -1, 1'b0, 2'b10, 0);

    exp_addr[0] = 32'h80; exp_addr[1] = 32'h84;
    burst(32'h80, 8'd1, 3'd2, 2'b01, 0, -1, 1'b1, 2'b00, 5);

    // Reset in the middle of a len-7 INCR burst
    axi_awaddr  = 32'h300;
    axi_awlen   = 8'd7;
    axi_awsize  = 3'd3;
    axi_awburst = 2'b01;
    axi_awvalid = 1'b1;
    step();
    axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi_wvalid = 1'b1;
      axi_wdata  = beat_data(i);
      axi_wstrb  = 8'hFF;
      step();
    end
    chk("pre_rst_addr", 64'(mem_addr), 64'h308);
    axi_wvalid = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_awready", 64'(axi_awready), 64'd1);
    chk("mid_rst_wready", 64'(axi_wready), 64'd0);
    chk("mid_rst_bvalid", 64'(axi_bvalid), 64'd0);
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    exp_addr[0] = 32'h500;
    burst(32'h500, 8'd0, 3'd3, 2'b01, 0, -1, 1'b1, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
